counter_cascade: RTL

- Parametrised multi-digit up/down counter for the stopwatch datapath.
- Chains NUM_DIGITS single-digit base-BASE counters with ripple-free carry/borrow lookahead.
- Supports synchronous parallel load, wrap or saturate at the limit, and a registered rollover pulse.
- Sits between the tick generator (enable) and the display digit mux.

---
 rtl/counter_cascade_pkg.sv | 25 ++
 rtl/counter_digit.sv | 59 +++++
 rtl/counter_cascade.sv | 102 ++++++++++
 3 files changed

// File: rtl/counter_cascade_pkg.sv
// ============================================================================
//  Module      : counter_cascade_pkg
//  Description : Shared helpers for the cascaded base-N counter: digit clamp,
//                digit maximum and packed-width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_cascade_pkg;

    function automatic int digit_max(input int base);
        return base - 1;
    endfunction

    function automatic int packed_width(input int num_digits, input int digit_bits);
        return num_digits * digit_bits;
    endfunction

    function automatic int unsigned clamp_digit(input int unsigned d, input int unsigned base);
        return (d >= base) ? (base - 1) : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_digit.sv
// ============================================================================
//  Module      : counter_digit
//  Description : One base-BASE up/down digit with synchronous load (clamped)
//                and a direction-aware at-limit flag for the carry lookahead.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_digit
    import counter_cascade_pkg::*;
#(
    parameter int BASE       = 10,
    parameter int DIGIT_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [DIGIT_BITS-1:0] load_digit,
    output logic [DIGIT_BITS-1:0] digit,
    output logic                  at_limit
);

    localparam logic [DIGIT_BITS-1:0] c_MAX = DIGIT_BITS'(digit_max(BASE));

    logic [DIGIT_BITS-1:0] r_digit;
    logic [DIGIT_BITS-1:0] w_eff;
    logic [DIGIT_BITS-1:0] w_load;
    logic [DIGIT_BITS-1:0] w_next;

    // An out-of-range digit behaves as BASE-1 for both stepping and lookahead.
    always_comb begin
        w_eff  = DIGIT_BITS'(clamp_digit(32'(r_digit), BASE));
        w_load = DIGIT_BITS'(clamp_digit(32'(load_digit), BASE));
        w_next = w_eff;
        if (up_down) begin
            w_next = (w_eff == c_MAX) ? '0 : w_eff + DIGIT_BITS'(1);
        end else begin
            w_next = (w_eff == '0) ? c_MAX : w_eff - DIGIT_BITS'(1);
        end
        at_limit = up_down ? (w_eff == c_MAX) : (w_eff == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_digit <= up_down ? '0 : c_MAX;
        end else if (load) begin
            r_digit <= w_load;
        end else if (step) begin
            r_digit <= w_next;
        end
    end

    assign digit = r_digit;

endmodule

`default_nettype wire

// File: rtl/counter_cascade.sv
// ============================================================================
//  Module      : counter_cascade
//  Description : NUM_DIGITS cascaded base-BASE up/down counter with lookahead
//                carry, load, wrap/saturate and registered rollover pulse.
//                Optional lap capture enabled by COUNTER_CASCADE_LAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_cascade
    import counter_cascade_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BASE       = 10,
    parameter int DIGIT_BITS = 4,
    parameter int SATURATE   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             up_down,
    input  logic                             load,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] load_value,
`ifdef COUNTER_CASCADE_LAP_EN
    input  logic                             lap,
    output logic [NUM_DIGITS*DIGIT_BITS-1:0] lap_value,
    output logic                             lap_valid,
`endif
    output logic [NUM_DIGITS*DIGIT_BITS-1:0] count,
    output logic                             terminal,
    output logic                             rollover
);

    localparam int c_W   = packed_width(NUM_DIGITS, DIGIT_BITS);
    localparam bit c_SAT = (SATURATE != 0);

    logic [NUM_DIGITS-1:0] w_at_limit;
    logic [NUM_DIGITS-1:0] w_step;
    logic [NUM_DIGITS:0]   w_below;
    logic                  w_advance;
    logic                  r_rollover;

    // w_below[i] is high when every digit under i sits at its limit.
    assign w_below[0] = 1'b1;
    assign terminal   = w_below[NUM_DIGITS];
    assign w_advance  = enable & ~load & ~(c_SAT & terminal);

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign w_below[i+1] = w_below[i] & w_at_limit[i];
            assign w_step[i]    = w_advance & w_below[i];

            counter_digit #(
                .BASE       (BASE),
                .DIGIT_BITS (DIGIT_BITS)
            ) u_digit (
                .clk        (clk),
                .rst        (rst),
                .step       (w_step[i]),
                .up_down    (up_down),
                .load       (load),
                .load_digit (load_value[i*DIGIT_BITS +: DIGIT_BITS]),
                .digit      (count[i*DIGIT_BITS +: DIGIT_BITS]),
                .at_limit   (w_at_limit[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= w_advance & terminal & ~c_SAT;
        end
    end

    assign rollover = r_rollover;

`ifdef COUNTER_CASCADE_LAP_EN
    logic [c_W-1:0] r_lap_value;
    logic           r_lap_valid;

    // Capture sees the pre-edge count, so a lap in a load cycle keeps the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lap_value <= '0;
            r_lap_valid <= 1'b0;
        end else if (lap) begin
            r_lap_value <= count;
            r_lap_valid <= 1'b1;
        end else if (load) begin
            r_lap_valid <= 1'b0;
        end
    end

    assign lap_value = r_lap_value;
    assign lap_valid = r_lap_valid;
`endif

endmodule

`default_nettype wire
